// File: rtl/udp_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_pkg
// Purpose  : Shared constants, types and helpers for the UDP transmit
//            scheduler: sender state codes, header sizes, default payload
//            limits, scheduler state enum and the payload length check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package udp_tx_pkg;

  // Sender state codes that the scheduler watches
  localparam logic [3:0] SND_IDLE    = 4'h0;
  localparam logic [3:0] SND_SENDCRC = 4'h7;

  // Header byte counts added to the payload length
  localparam logic [15:0] UDP_HDR    = 16'd8;
  localparam logic [15:0] IP_UDP_HDR = 16'd28;

  // Default legal payload range in bytes
  localparam int unsigned DEF_MIN_LEN = 16;
  localparam int unsigned DEF_MAX_LEN = 1472;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } sched_state_t;

  // Payload must sit inside [min_len, max_len] and be word aligned
  function automatic logic len_ok(input logic [15:0] len,
                                  input int unsigned min_len,
                                  input int unsigned max_len);
    return (32'(len) >= min_len) && (32'(len) <= max_len) && (len[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_if
// Purpose  : Bus between the scheduler and the UDP/IP sender.
// Signals  : tx_enable, tx_data_length, tx_total_length, fifo_dout, empty
//            (scheduler -> sender); tx_state, fifo_rden (sender -> scheduler)
// Modports : master = scheduler side, slave = sender side
// Revision : 1.0 - initial release
// ============================================================================
interface udp_tx_if;
  logic        tx_enable;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic [3:0]  tx_state;
  logic [31:0] fifo_dout;
  logic        empty;
  logic        fifo_rden;

  modport master (
    output tx_enable, tx_data_length, tx_total_length, fifo_dout, empty,
    input  tx_state, fifo_rden
  );

  modport slave (
    input  tx_enable, tx_data_length, tx_total_length, fifo_dout, empty,
    output tx_state, fifo_rden
  );
endinterface
`default_nettype wire

// File: rtl/udp_tx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_rr_arb
// Purpose  : Two-way round-robin arbiter. The pointer channel wins a tie;
//            on an advance strobe the pointer moves to the channel other
//            than cur.
// Ports    : clk, reset (async, active high), req[1:0], advance, cur,
//            any (some request present), winner (selected channel)
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       cur,
  output logic       any,
  output logic       winner
);

  logic ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~cur;
    end
  end

  assign any    = |req;
  assign winner = req[ptr] ? ptr : ~ptr;

endmodule
`default_nettype wire

// File: rtl/udp_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_scheduler
// Purpose  : Shares one UDP/IP sender between two channels. Arbitrates
//            round-robin, validates payload length, loads header lengths,
//            routes the winning channel's FIFO to the sender, detects frame
//            completion, runs a frame watchdog and enforces an inter-frame gap.
// Ports    : clk, reset (async, active high)
//            ch_req/ch_len/ch_gnt/ch_done/ch_err   - per-channel control
//            ch_fifo_dout/ch_empty/ch_fifo_rden    - per-channel FIFO side
//            tx (udp_tx_if.master)                 - sender bus
//            busy, active_ch, frame_count          - status
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_scheduler
  import udp_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 32'h0800_0000,
  parameter int unsigned MIN_LEN        = DEF_MIN_LEN,
  parameter int unsigned MAX_LEN        = DEF_MAX_LEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    ch_req,
  input  logic [31:0]   ch_len,
  output logic [1:0]    ch_gnt,
  output logic [1:0]    ch_done,
  output logic [1:0]    ch_err,
  input  logic [63:0]   ch_fifo_dout,
  input  logic [1:0]    ch_empty,
  output logic [1:0]    ch_fifo_rden,
  udp_tx_if.master      tx,
  output logic          busy,
  output logic          active_ch,
  output logic [15:0]   frame_count
);

  // Last watchdog count before timeout, and gap length (zero still gives one)
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD = (IFG_CYCLES == 0) ? 32'd1 : 32'(IFG_CYCLES);

  sched_state_t state;
  logic         seen_crc;
  logic [31:0]  wd_cnt;
  logic [31:0]  gap_cnt;

  logic         arb_any;
  logic         arb_winner;
  logic         arb_adv;
  logic         arb_cur;
  logic [15:0]  win_len;
  logic [15:0]  act_len;
  logic         win_ok;
  logic         send_done;
  logic         send_tmo;

  assign win_len   = arb_winner ? ch_len[31:16] : ch_len[15:0];
  assign act_len   = active_ch  ? ch_len[31:16] : ch_len[15:0];
  assign win_ok    = len_ok(win_len, MIN_LEN, MAX_LEN);

  // Completion needs SENDCRC on an earlier cycle, then sender IDLE now
  assign send_done = (state == S_SEND) && seen_crc && (tx.tx_state == SND_IDLE);
  assign send_tmo  = (state == S_SEND) && !send_done && (wd_cnt == WD_LAST);

  // Pointer must move in the same cycle as a rejection so the next IDLE
  // cycle already arbitrates from the other channel
  assign arb_adv   = ((state == S_IDLE) && arb_any && !win_ok) || send_done || send_tmo;
  assign arb_cur   = (state == S_IDLE) ? arb_winner : active_ch;

  udp_tx_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (ch_req),
    .advance (arb_adv),
    .cur     (arb_cur),
    .any     (arb_any),
    .winner  (arb_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      seen_crc           <= 1'b0;
      wd_cnt             <= '0;
      gap_cnt            <= '0;
      ch_gnt             <= '0;
      ch_done            <= '0;
      ch_err             <= '0;
      tx.tx_enable       <= 1'b0;
      tx.tx_data_length  <= '0;
      tx.tx_total_length <= '0;
      busy               <= 1'b0;
      active_ch          <= 1'b0;
      frame_count        <= '0;
    end else begin
      ch_gnt  <= '0;
      ch_done <= '0;
      ch_err  <= '0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            if (!win_ok) begin
              ch_err[arb_winner] <= 1'b1;
            end else begin
              active_ch <= arb_winner;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          tx.tx_data_length    <= act_len + UDP_HDR;
          tx.tx_total_length   <= act_len + IP_UDP_HDR;
          ch_gnt[active_ch]    <= 1'b1;
          tx.tx_enable         <= 1'b1;
          busy                 <= 1'b1;
          wd_cnt               <= '0;
          seen_crc             <= 1'b0;
          state                <= S_SEND;
        end
        S_SEND: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (tx.tx_state == SND_SENDCRC) begin
            seen_crc <= 1'b1;
          end
          if (send_done || send_tmo) begin
            if (send_done) begin
              ch_done[active_ch] <= 1'b1;
              frame_count        <= frame_count + 16'd1;
            end else begin
              ch_err[active_ch]  <= 1'b1;
            end
            tx.tx_enable <= 1'b0;
            busy         <= 1'b0;
            gap_cnt      <= GAP_LOAD;
            state        <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt <= 32'd1) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency FIFO routing; parked (empty, no data, no reads) outside a frame
  always_comb begin
    tx.fifo_dout = '0;
    tx.empty     = 1'b1;
    ch_fifo_rden = '0;
    if ((state == S_LOAD) || (state == S_SEND)) begin
      tx.fifo_dout            = active_ch ? ch_fifo_dout[63:32] : ch_fifo_dout[31:0];
      tx.empty                = ch_empty[active_ch];
      ch_fifo_rden[active_ch] = tx.fifo_rden;
    end
  end

endmodule
`default_nettype wire

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12: idle cycles forced between frames.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'h0800_0000: frame watchdog limit, larger than the sender's idle delay.
REQ-003 SHALL have parameters MIN_LEN, default 16, and MAX_LEN, default 1472: legal payload byte range.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; all other ports follow in REQ-005 to REQ-021.
REQ-005 clk  in  1  sole clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 ch_req  in  2  per-channel frame request; level signal.
REQ-008 ch_len  in  32  payload bytes; [15:0] = ch0, [31:16] = ch1; stable while the request is high.
REQ-009 ch_gnt  out  2  one-cycle grant pulse.
REQ-010 ch_done  out  2  one-cycle frame-complete pulse.
REQ-011 ch_err  out  2  one-cycle pulse on rejected length or timeout.
REQ-012 ch_fifo_dout  in  64  channel FIFO words; [31:0] = ch0, [63:32] = ch1.
REQ-013 ch_empty  in  2  channel FIFO empty flags.
REQ-014 ch_fifo_rden  out  2  routed read enables.
REQ-015 tx_enable  out  1  sender enable.
REQ-016 tx_data_length  out  16  UDP length.
REQ-017 tx_total_length  out  16  IP total length.
REQ-018 tx_state  in  4  sender state.
REQ-019 fifo_dout  out  32  muxed word to the sender.
REQ-020 empty  out  1  muxed empty flag to the sender.
REQ-021 fifo_rden  in  1  sender read enable; busy out 1; active_ch out 1; frame_count out 16.

Function
REQ-022 States SHALL be IDLE, LOAD, SEND, GAP.
REQ-023 IDLE: if any ch_req is high, the round-robin winner SHALL be picked, starting at the pointer; both channels high selects the pointer channel.
REQ-024 IDLE, winner's length invalid (below MIN_LEN, above MAX_LEN, or not a multiple of 4): the winner's ch_err SHALL pulse, the pointer SHALL move to the other channel, and the state SHALL stay IDLE.
REQ-025 IDLE, winner's length valid: next state SHALL be LOAD and active_ch SHALL take the winner.
REQ-026 LOAD (one cycle): tx_data_length SHALL register len+8, tx_total_length SHALL register len+28 (16-bit), ch_gnt[active_ch] SHALL pulse, then the state SHALL go to SEND.
REQ-027 Lengths SHALL hold stable until the next LOAD.
REQ-028 SEND: tx_enable=1 and busy=1.
REQ-029 Frame completion SHALL be tx_state==4'h7 (sendcrc) seen on one cycle, then tx_state==4'h0 seen on a later cycle.
REQ-030 On completion: ch_done[active_ch] SHALL pulse, frame_count SHALL increment (wraps FFFF->0), the pointer SHALL move to the other channel, and the state SHALL go to GAP.
REQ-031 Watchdog: it SHALL count cycles in SEND and reset on entry to SEND.
REQ-032 At TIMEOUT_CYCLES with no completion: tx_enable SHALL drop, ch_err[active_ch] SHALL pulse, the pointer SHALL advance, and the state SHALL go to GAP; frame_count SHALL NOT change.
REQ-033 GAP: tx_enable=0 for exactly IFG_CYCLES cycles, then IDLE; IFG_CYCLES=0 SHALL give one GAP cycle.
REQ-034 Mux in LOAD/SEND: fifo_dout SHALL be ch_fifo_dout of active_ch, empty SHALL be ch_empty[active_ch], and ch_fifo_rden[active_ch] SHALL be fifo_rden.
REQ-035 Mux in IDLE/GAP: empty=1, fifo_dout=0, ch_fifo_rden=0.
REQ-036 Mux paths SHALL be combinational, zero latency.
REQ-037 ch_req deasserting during LOAD/SEND SHALL be ignored; the frame completes.
REQ-038 Each grant SHALL yield exactly one frame; a held request SHALL be re-arbitrated after GAP.
REQ-039 ch_gnt, ch_done, and ch_err SHALL be mutually exclusive per cycle.

Reset
REQ-040 While reset is high, outputs SHALL be asynchronously forced: tx_enable=0, lengths=0, ch_gnt=ch_done=ch_err=0, ch_fifo_rden=0, empty=1, fifo_dout=0, busy=0, active_ch=0, frame_count=0.
REQ-041 While reset is high: state=IDLE, pointer=ch0, watchdog=0.
REQ-042 Reset mid-frame SHALL abort without a ch_done or ch_err pulse.

Structure
REQ-043 Package udp_tx_pkg SHALL hold: sender state codes (IDLE 4'h0, SENDCRC 4'h7), UDP_HDR=8, IP_UDP_HDR=28, default MIN_LEN/MAX_LEN, and the scheduler state enum.
REQ-044 Sub-module udp_tx_rr_arb SHALL contain the 2-way round-robin arbiter, with the pointer update as an input strobe.

Verification
REQ-045 ch0 len=64, ch1 idle -> ch0 gnt, tx_data_length=72, tx_total_length=92; tx_state 7 then 0 -> ch0 done, frame_count=1.
REQ-046 Both req len=32 from reset -> grant order ch0, ch1, ch0; >=IFG_CYCLES tx_enable-low cycles between frames.
REQ-047 ch1 len=15, then len=1476, then len=18 -> three ch1 err pulses, no gnt, tx_enable stays 0.
REQ-048 TIMEOUT_CYCLES=100, tx_state stuck 4'h3 -> ch_err at cycle 100 of SEND, tx_enable=0, frame_count unchanged.
REQ-049 Reset asserted mid-SEND on ch1 -> tx_enable=0 and empty=1 same cycle; after release, ch0 is arbitrated first.
REQ-050 During SEND on ch1 -> fifo_rden toggles only ch_fifo_rden[1]; fifo_dout equals ch_fifo_dout[63:32] every cycle.
